// File: rtl/lcd_sequencer.sv
// HD44780-style LCD write sequencer.
// On power-up it waits, issues a fixed four-command init sequence, and then
// accepts host instruction/data writes one at a time. Each write is shaped
// into a setup / enable-high / hold / execution-wait bus cycle.
module lcd_sequencer #(
    parameter int   POWERUP_CYC = 1500000,
    parameter int   EN_CYC      = 25,
    parameter int   CMD_CYC     = 1950,
    parameter int   CLEAR_CYC   = 76500,
    parameter logic LINES2      = 1'b1,
    parameter logic FONT5X10    = 1'b0,
    parameter logic CURSOR_ON   = 1'b1,
    parameter logic BLINK_ON    = 1'b1,
    parameter logic ENTRY_INC   = 1'b1,
    parameter logic ENTRY_SHIFT = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       WrValid,
    input  logic       WrRS,
    input  logic [7:0] WrData,
    output logic       WrReady,
    output logic       InitDone,
    output logic [2:0] State,
    output logic       Enable,
    output logic       RS,
    output logic       RW,
    output logic [7:0] Data
);

    localparam logic [2:0] PWR_WAIT  = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] EN_HIGH   = 3'd2;
    localparam logic [2:0] HOLD      = 3'd3;
    localparam logic [2:0] EXEC_WAIT = 3'd4;
    localparam logic [2:0] IDLE      = 3'd5;

    // Counter only has to reach (largest delay - 1); keep at least one bit.
    localparam int MAX_A   = (POWERUP_CYC > EN_CYC)   ? POWERUP_CYC : EN_CYC;
    localparam int MAX_B   = (CMD_CYC     > CLEAR_CYC) ? CMD_CYC     : CLEAR_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             clear_cmd;
    logic [CNT_W-1:0] exec_last;

    // Init commands: function set, display control, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = {4'b0011, LINES2, FONT5X10, 2'b00};
            2'd1:    init_cmd = {5'b00001, 1'b1, CURSOR_ON, BLINK_ON};
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = {5'b00000, 1'b1, ENTRY_INC, ENTRY_SHIFT};
        endcase
    endfunction

    // Clear display / return home need the long execution wait.
    assign clear_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign exec_last = clear_cmd ? CLR_LAST : CMD_LAST;

    assign WrReady  = (state_q == IDLE) && done_q;
    assign InitDone = done_q;
    assign State    = state_q;
    assign Enable   = (state_q == EN_HIGH);
    assign RS       = rs_q;
    assign RW       = 1'b0;
    assign Data     = data_q;

    // Next-state logic: sequencing, delay counting and bus-value capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                    state_d = SETUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = EN_HIGH;
            end
            EN_HIGH: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                cnt_d   = '0;
                state_d = EXEC_WAIT;
            end
            EXEC_WAIT: begin
                if (cnt_q == exec_last) begin
                    cnt_d = '0;
                    if (done_q) begin
                        state_d = IDLE;
                    end else if (idx_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = init_cmd(idx_q + 2'd1);
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (WrValid && WrReady) begin
                    rs_d    = WrRS;
                    data_d  = WrData;
                    state_d = SETUP;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = PWR_WAIT;
            end
        endcase
    end

    // State registers; reset drops Enable at once since it decodes state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= PWR_WAIT;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with short delays.
module tb_lcd_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       WrValid = 1'b0;
    logic       WrRS = 1'b0;
    logic [7:0] WrData = 8'h00;
    logic       WrReady, InitDone, Enable, RS, RW;
    logic [2:0] State;
    logic [7:0] Data;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    lcd_sequencer #(
        .POWERUP_CYC(10),
        .EN_CYC     (2),
        .CMD_CYC    (4),
        .CLEAR_CYC  (8)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .WrValid (WrValid),
        .WrRS    (WrRS),
        .WrData  (WrData),
        .WrReady (WrReady),
        .InitDone(InitDone),
        .State   (State),
        .Enable  (Enable),
        .RS      (RS),
        .RW      (RW),
        .Data    (Data)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge Clock);
        edge_n++;
        @(negedge Clock);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, State, 3'd0);
        check({tag, "_en"}, Enable, 1'b0);
        check({tag, "_rs"}, RS, 1'b0);
        check({tag, "_rw"}, RW, 1'b0);
        check({tag, "_data"}, Data, 8'h00);
        check({tag, "_done"}, InitDone, 1'b0);
        check({tag, "_rdy"}, WrReady, 1'b0);
    endtask

    // Walks the init sequence from release (edge 0) to edge 46.
    task automatic init_run();
        run_to(9);  check("pwr_state9", State, 3'd0); check("pwr_en9", Enable, 1'b0);
        run_to(10); check("c0_setup", State, 3'd1); check("c0_data", Data, 8'h38);
                    check("c0_rs", RS, 1'b0); check("c0_en_lo", Enable, 1'b0);
        run_to(11); check("c0_en1", Enable, 1'b1);
        run_to(12); check("c0_en2", Enable, 1'b1); check("c0_data_en", Data, 8'h38);
        run_to(13); check("c0_hold", State, 3'd3); check("c0_en_off", Enable, 1'b0);
                    check("c0_data_hold", Data, 8'h38);
        run_to(17); check("c0_exec_last", State, 3'd4);
        run_to(18); check("c1_setup", State, 3'd1); check("c1_data", Data, 8'h0F);
        run_to(26); check("c2_setup", State, 3'd1); check("c2_data", Data, 8'h01);
        run_to(27); check("c2_en1", Enable, 1'b1);
        run_to(29); check("c2_hold", State, 3'd3);
        run_to(33); check("c2_exec_mid", State, 3'd4);
        run_to(37); check("c2_exec_last", State, 3'd4); check("c2_data_exec", Data, 8'h01);
        run_to(38); check("c3_setup", State, 3'd1); check("c3_data", Data, 8'h06);
                    check("c3_rs", RS, 1'b0);
        run_to(45); check("c3_exec_last", State, 3'd4); check("done45", InitDone, 1'b0);
                    check("rdy45", WrReady, 1'b0);
        run_to(46); check("idle46", State, 3'd5); check("done46", InitDone, 1'b1);
                    check("rdy46", WrReady, 1'b1);
    endtask

    // Host write from IDLE; measures enable width and execution wait.
    task automatic do_write(input string tag, input logic rs, input logic [7:0] d, input int exp_exec);
        int en_cnt;
        int ex_cnt;
        int guard;
        int unstable;
        WrValid = 1'b1;
        WrRS    = rs;
        WrData  = d;
        step();
        WrValid = 1'b0;
        check({tag, "_setup"}, State, 3'd1);
        check({tag, "_rs"}, RS, rs);
        check({tag, "_data"}, Data, d);
        check({tag, "_rdy_lo"}, WrReady, 1'b0);
        en_cnt = 0; ex_cnt = 0; guard = 0; unstable = 0;
        while (State != 3'd5 && guard < 40) begin
            step();
            guard++;
            if (Enable) en_cnt++;
            if (State == 3'd4) ex_cnt++;
            if (State != 3'd5 && (Data !== d || RS !== rs)) unstable++;
        end
        check({tag, "_timeout"}, (guard < 40), 1'b1);
        check({tag, "_en_w"}, en_cnt, 2);
        check({tag, "_exec_w"}, ex_cnt, exp_exec);
        check({tag, "_stable"}, unstable, 0);
        check({tag, "_rdy_back"}, WrReady, 1'b1);
    endtask

    initial begin
        // Reset held with a pending host write.
        WrValid = 1'b1; WrRS = 1'b1; WrData = 8'h41;
        #23;
        check_reset_outputs("rst");
        @(negedge Clock);
        Reset = 1'b1;
        edge_n = 0;
        init_run();

        // Held request transfers at the first IDLE edge.
        run_to(47);
        WrValid = 1'b0;
        check("hw_setup", State, 3'd1); check("hw_rs", RS, 1'b1);
        check("hw_data", Data, 8'h41); check("hw_rdy_lo", WrReady, 1'b0);
        run_to(48); check("hw_en1", Enable, 1'b1);
        run_to(49); check("hw_en2", Enable, 1'b1);
        run_to(50); check("hw_hold", State, 3'd3); check("hw_en_off", Enable, 1'b0);
        run_to(54); check("hw_exec_last", State, 3'd4); check("hw_rdy54", WrReady, 1'b0);
        run_to(55); check("hw_idle", State, 3'd5); check("hw_rdy55", WrReady, 1'b1);
                    check("hw_keep_data", Data, 8'h41); check("hw_keep_rs", RS, 1'b1);
        run_to(58); check("hw_no_second", State, 3'd5);

        do_write("w02", 1'b0, 8'h02, 8);
        do_write("w80", 1'b0, 8'h80, 4);
        do_write("w01d", 1'b1, 8'h01, 4);

        // Asynchronous reset after init clears InitDone immediately.
        #2 Reset = 1'b0;
        #1 check_reset_outputs("rst_idle");
        @(negedge Clock);
        Reset = 1'b1;
        edge_n = 0;

        // Reset during Enable high of the clear command.
        run_to(27);
        check("clr_en_hi", Enable, 1'b1); check("clr_data", Data, 8'h01);
        #2 Reset = 1'b0;
        #1 check_reset_outputs("rst_en");
        @(negedge Clock);
        Reset = 1'b1;
        edge_n = 0;
        init_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 1500000: power-on wait in clocks (30 ms at 50 MHz).
REQ-002 SHALL have parameter EN_CYC, default 25: Enable high width in clocks.
REQ-003 SHALL have parameter CMD_CYC, default 1950: execution wait in clocks for ordinary instructions and data writes (39 us).
REQ-004 SHALL have parameter CLEAR_CYC, default 76500: execution wait in clocks for clear/home (1.53 ms).
REQ-005 SHALL have parameters LINES2=1, FONT5X10=0, CURSOR_ON=1, BLINK_ON=1, ENTRY_INC=1, ENTRY_SHIFT=0, each 1 bit, setting the N, F, C, B, I/D and S fields of the init commands.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: Clock, input, 1, system clock, rising edge.
REQ-007 Reset, input, 1, asynchronous active-low reset.
REQ-008 WrValid, input, 1, host write request.
REQ-009 WrRS, input, 1, register select of the host write (0 = instruction, 1 = data).
REQ-010 WrData, input, 8, byte to write.
REQ-011 WrReady, output, 1, block accepts a host write this cycle.
REQ-012 InitDone, output, 1, power-on init sequence complete.
REQ-013 State, output, 3, current FSM state.
REQ-014 Enable, RS, RW, output, 1 each, LCD control pins.
REQ-015 Data, output, 8, LCD data bus.

Function
REQ-016 SHALL implement FSM states PWR_WAIT=0, SETUP=1, EN_HIGH=2, HOLD=3, EXEC_WAIT=4, IDLE=5; codes 6-7 SHALL go to PWR_WAIT.
REQ-017 PWR_WAIT SHALL last exactly POWERUP_CYC cycles, then go to SETUP with init command 0.
REQ-018 Init sequence, fixed order: 0x30|LINES2<<3|FONT5X10<<2; 0x0C|CURSOR_ON<<1|BLINK_ON; 0x01; 0x04|ENTRY_INC<<1|ENTRY_SHIFT; all with RS=0.
REQ-019 Each write SHALL be: SETUP 1 cycle (Enable=0, RS/Data valid), EN_HIGH exactly EN_CYC cycles (Enable=1), HOLD 1 cycle (Enable=0, RS/Data held), EXEC_WAIT exactly W cycles.
REQ-020 W SHALL be CLEAR_CYC when RS=0 and Data[7:2]==0 and Data[1:0]!=0; otherwise CMD_CYC.
REQ-021 After EXEC_WAIT, the next init command SHALL go to SETUP; after the 4th, the FSM SHALL enter IDLE and set InitDone=1; InitDone SHALL remain 1 until reset.
REQ-022 WrReady SHALL be 1 only in IDLE with InitDone=1 (combinational from state).
REQ-023 A host write SHALL transfer on a rising edge with WrValid=1 and WrReady=1; WrRS and WrData are captured at that edge and the next cycle is SETUP.
REQ-024 WrValid while WrReady=0 SHALL be ignored; there is no queue, and the host holds WrValid.
REQ-025 RS and Data SHALL stay stable from SETUP through the end of EXEC_WAIT and hold their last value in IDLE.
REQ-026 RW SHALL be constant 0 (write-only).
REQ-027 Delay counters SHALL be sized by $clog2 of the largest delay parameter and SHALL NOT wrap; all delay parameters are >=1.

Reset
REQ-028 Reset=0 SHALL force immediately: State=PWR_WAIT, Enable=0, RS=0, RW=0, Data=0x00, InitDone=0, WrReady=0, counters=0, init index=0.
REQ-029 Reset asserted mid-operation, including Enable high, SHALL drop Enable at once; after release the full PWR_WAIT and init sequence restart.
REQ-030 The first cycle of PWR_WAIT SHALL count on the first rising edge with Reset=1.

Verification (POWERUP_CYC=10, EN_CYC=2, CMD_CYC=4, CLEAR_CYC=8, other parameters default)
REQ-031 Release reset -> Enable pulses carry Data 0x38, 0x0F, 0x01, 0x06 in order, RS=0; InitDone rises on the 46th rising edge after release.
REQ-032 Each Enable pulse -> high exactly 2 cycles, Data stable 1 cycle before and 1 cycle after; gap to the next SETUP is 4 cycles, or 8 after 0x01.
REQ-033 In IDLE, WrValid=1, WrRS=1, WrData=0x41 -> WrReady drops the next cycle, RS=1 Data=0x41 with 2-cycle Enable, WrReady returns after 8 cycles.
REQ-034 Host write RS=0 0x02 -> 8-cycle EXEC_WAIT; RS=0 0x80 -> 4-cycle; RS=1 0x01 -> 4-cycle.
REQ-035 WrValid held high during init -> no transfer until IDLE, then exactly one transfer per accepted handshake.
REQ-036 Reset pulsed low during EN_HIGH of the clear command -> Enable=0 and all outputs at reset values immediately; the full init repeats, 46 cycles after release.
